// File: rtl/mem_stage_dcache_if.sv
// Pipeline-side (load/store request, hit/readData) and main-memory-side buses
// of the MEM-stage data cache; master is the environment, slave is the cache.
interface mem_stage_dcache_if;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] addr;
   logic [31:0] writeData;
   logic        hit;
   logic [31:0] readData;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output MemRead, MemWrite, addr, writeData, mem_rdata, mem_ack,
      input  hit, readData, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  MemRead, MemWrite, addr, writeData, mem_rdata, mem_ack,
      output hit, readData, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_stage_dcache.sv
// Direct-mapped, one-word-line, write-through/no-write-allocate data cache for the MEM stage.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module mem_stage_dcache #(
   parameter int LINES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_stage_dcache_if.slave bus
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count
`endif
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR_THRU = 2'd2,
      WR_DONE = 2'd3
   } state_t;

   state_t           r_state;
   logic [LINES-1:0] r_valid;
   logic [TAG_W-1:0] r_tag  [LINES];
   logic [31:0]      r_data [LINES];
   logic             r_mem_req;
   logic             r_mem_we;

   logic [IDX_W-1:0] w_index;
   logic [TAG_W-1:0] w_tag;
   logic             w_match;
   logic             w_rd_req;
   logic             w_rd_hit;
   logic             w_miss_start;
   logic             w_fill;
   logic             w_wr_upd;
   logic             w_hit;
   logic             w_unused_addr_bits;

   assign w_index            = bus.addr[IDX_W+1:2];
   assign w_tag              = bus.addr[31:IDX_W+2];
   assign w_unused_addr_bits = ^bus.addr[1:0];

   assign w_match      = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_rd_req     = bus.MemRead && !bus.MemWrite;
   assign w_rd_hit     = (r_state == IDLE) && w_rd_req && w_match;
   assign w_miss_start = (r_state == IDLE) && w_rd_req && !w_match;
   assign w_fill       = (r_state == RD_MISS) && bus.mem_ack;
   assign w_wr_upd     = (r_state == WR_THRU) && bus.mem_ack && w_match;

   // Idle with no request counts as "complete" so the MEM/WB register advances.
   assign w_hit = (r_state == WR_DONE) ||
                  ((r_state == IDLE) && ((!bus.MemRead && !bus.MemWrite) || w_rd_hit));

   assign bus.hit       = w_hit;
   assign bus.readData  = w_rd_hit ? r_data[w_index] : 32'd0;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = {bus.addr[31:2], 2'b00};
   assign bus.mem_wdata = bus.writeData;

   // Reset clears state and valid bits, so an in-flight transfer is abandoned unwritten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_valid   <= '0;
         r_mem_req <= 1'b0;
         r_mem_we  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.MemWrite) begin
                  r_state   <= WR_THRU;
                  r_mem_req <= 1'b1;
                  r_mem_we  <= 1'b1;
               end else if (w_miss_start) begin
                  r_state   <= RD_MISS;
                  r_mem_req <= 1'b1;
                  r_mem_we  <= 1'b0;
               end
            end
            RD_MISS: begin
               if (bus.mem_ack) begin
                  r_valid[w_index] <= 1'b1;
                  r_state          <= IDLE;
                  r_mem_req        <= 1'b0;
               end
            end
            WR_THRU: begin
               if (bus.mem_ack) begin
                  r_state   <= WR_DONE;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
               end
            end
            WR_DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Tag/data arrays carry no reset; valid bits alone qualify their contents.
   always_ff @(posedge clk) begin
      if (w_fill) begin
         r_tag[w_index]  <= w_tag;
         r_data[w_index] <= bus.mem_rdata;
      end else if (w_wr_upd) begin
         r_data[w_index] <= bus.writeData;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [15:0] r_hit_count;
   logic [15:0] r_miss_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_count  <= 16'd0;
         r_miss_count <= 16'd0;
      end else begin
         if (w_rd_hit && (r_hit_count != 16'hFFFF)) begin
            r_hit_count <= r_hit_count + 16'd1;
         end
         if (w_miss_start && (r_miss_count != 16'hFFFF)) begin
            r_miss_count <= r_miss_count + 16'd1;
         end
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`endif

endmodule

// File: doc/mem_stage_dcache.md
MEM_STAGE_DCACHE -- requirements
Module: mem_stage_dcache

Interface
REQ-001 SHALL have parameter LINES, default 16, giving the number of direct-mapped one-word cache lines (power of two, 2..256).
REQ-002 SHALL have ports `clk`, input, 1: the single clock; all state changes on posedge.
REQ-003 SHALL have port `rst_n`, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports `MemRead` and `MemWrite`, input, 1 each: the load and store requests from the EX/MEM stage.
REQ-005 SHALL have port `addr`, input, 32: the byte address; bits [1:0] are ignored.
REQ-006 SHALL have port `writeData`, input, 32: the store data.
REQ-007 SHALL have port `hit`, output, 1: access complete; it is the stall/advance qualifier for the MEM/WB register.
REQ-008 SHALL have port `readData`, output, 32: the load result, valid while `hit`=1 with a read.
REQ-009 SHALL have main-memory ports: `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32, `mem_rdata` in 32, `mem_ack` in 1.

Function
REQ-010 SHALL decode the address as follows:
- index = addr[2+log2(LINES)-1:2];
- tag = remaining upper bits;
- each line holds valid, tag and 32-bit data.
REQ-011 SHALL implement the FSM states IDLE, RD_MISS, WR_THRU and WR_DONE.
REQ-012 In IDLE with MemRead=MemWrite=0, `hit` SHALL be 1 and `readData` SHALL be 0.
REQ-013 In IDLE with MemRead=1, MemWrite=0 and a valid tag match, `hit` SHALL be 1 combinationally, `readData` SHALL equal the line data, and the state SHALL remain IDLE (zero-cycle hit).
REQ-014 In IDLE with MemRead=1, MemWrite=0 and a miss, the block SHALL:
- drive `hit`=0;
- go to RD_MISS at the next posedge.
REQ-015 In IDLE with MemWrite=1, the block SHALL drive `hit`=0 and go to WR_THRU at the next posedge. MemWrite has priority when both requests are high.
REQ-016 In RD_MISS the outputs SHALL be:
- `mem_req`=1, `mem_we`=0;
- `mem_addr`={addr[31:2],2'b00};
- `hit`=0.
REQ-017 In RD_MISS, at the posedge with `mem_ack`=1, the block SHALL write the line (valid=1, tag, data=`mem_rdata`) and go to IDLE, where REQ-013 then yields `hit`=1.
REQ-018 In WR_THRU the outputs SHALL be:
- `mem_req`=1, `mem_we`=1;
- `mem_addr` as in REQ-016;
- `mem_wdata`=`writeData`;
- `hit`=0.
REQ-019 In WR_THRU, at the posedge with `mem_ack`=1:
- if the line is valid and the tag matches, its data SHALL be updated to `writeData`;
- if not, there SHALL be no allocation (write-through, no-write-allocate);
- the state SHALL go to WR_DONE.
REQ-020 In WR_DONE, `hit` SHALL be 1 and `mem_req` SHALL be 0, and the state SHALL go to IDLE unconditionally at the next posedge.
REQ-021 `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` SHALL be stable from request assertion until the ack posedge. `mem_req` SHALL be 0 in IDLE and WR_DONE.
REQ-022 `mem_ack` SHALL be ignored in IDLE and WR_DONE.
REQ-023 The upstream stage holds `MemRead`, `MemWrite`, `addr` and `writeData` stable while `hit`=0; the block SHALL NOT re-sample them mid-miss.
REQ-024 Miss latency SHALL be (cycles to ack)+1 cycles of `hit`=0. Store latency SHALL be (cycles to ack)+1 cycles of `hit`=0, followed by the WR_DONE cycle.

Reset
REQ-025 On `rst_n`=0, asynchronously:
- state = IDLE;
- all valid bits = 0;
- `mem_req`=0, `mem_we`=0;
- counters (REQ-028) = 0.
Data and tag arrays SHALL NOT be reset.
REQ-026 Reset asserted during RD_MISS or WR_THRU SHALL drop `mem_req` immediately and abandon the transfer; no line SHALL be written.
REQ-027 After reset release, the first read of any address SHALL miss.

Configuration
REQ-028 With macro DCACHE_STATS_EN defined, the block SHALL add outputs `hit_count` and `miss_count`, each 16 bits:
- `hit_count` increments on each posedge where REQ-013 applies;
- `miss_count` increments on each IDLE->RD_MISS transition;
- both saturate at 16'hFFFF.
REQ-029 Without DCACHE_STATS_EN, those ports and registers SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-030 Reset, then read 0x00000040 with an ack 3 cycles later and `mem_rdata`=0xDEADBEEF -> 4 cycles `hit`=0, then `hit`=1 with `readData`=0xDEADBEEF; a repeat read hits in 0 cycles.
REQ-031 Write 0x00000040 with 0x12345678 after the line is cached, ack after 1 cycle -> `mem_we`=1, `mem_wdata`=0x12345678; WR_DONE `hit`=1; a following read hits with 0x12345678 and no `mem_req`.
REQ-032 Write 0x00000080 (uncached) -> memory is written; a following read of 0x00000080 misses (no allocate).
REQ-033 Read 0x00000040 then 0x00000440 (same index, LINES=16) -> both miss; re-reading 0x00000040 misses again (eviction).
REQ-034 Assert `rst_n`=0 mid-RD_MISS -> `mem_req`=0 that same cycle; after release a read of the same address misses.
REQ-035 With DCACHE_STATS_EN: 2 hits and 1 miss -> `hit_count`=2, `miss_count`=1; force 65536 hits -> `hit_count` stays 0xFFFF.
